mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// Memory-stage controller. It sits between the X/M pipeline latch and the M/W latch.
// - Consumes the latched ir/o/b words and decodes lw/sw.
// - Runs a req/ready handshake with a multi-cycle data memory.
// - Stalls the front of the pipeline while the access is outstanding.
// - Presents ir, o and load data, with a valid flag, to the M/W latch.
// PARAMETERS
// ADDR_W   12  dmem word-address width; dmem_addr = o_in[ADDR_W-1:0]
// TIMEOUT  64  max ACCESS cycles without dmem_ready before abort; 0 = never abort
// PORTS
// clock        in   1       rising-edge clock
// reset        in   1       synchronous, active-high reset
// ir_in        in   32      instruction from X/M latch; opcode = ir_in[31:27]
// o_in         in   32      ALU result / effective address from X/M latch
// b_in         in   32      store data from X/M latch
// dmem_ready   in   1       memory completes current request this cycle
// dmem_rdata   in   32      load data; valid when dmem_ready=1 and dmem_we=0
// dmem_req     out  1       access request, held until ready or abort
// dmem_we      out  1       1 = store, 0 = load
// dmem_addr    out  ADDR_W  word address
// dmem_wdata   out  32      store data
// stall        out  1       hold F/D/X and X/M latches this cycle (combinational)
// ir_out       out  32      instruction to M/W latch
// o_out        out  32      ALU result to M/W latch
// d_out        out  32      load data to M/W latch (0 for non-loads)
// valid_out    out  1       ir_out/o_out/d_out carry a real instruction
// err_out      out  1       sticky: a memory access timed out
// BEHAVIOUR
// - Opcodes: lw = 5'b01000, sw = 5'b00111. All others are non-memory. ir_in == 0 is a nop.
// - Reset: every output is 0, state = IDLE, timeout counter = 0. Applies mid-access too:
//   dmem_req is 0 after the reset edge, with no completion or valid.
// - State machine: IDLE, ACCESS.
//   - IDLE, non-memory op: stall = 0. At the edge:
//     - ir_out <= ir_in, o_out <= o_in, d_out <= 0.
//     - valid_out <= (ir_in != 0).
//     - Latency is 1 cycle.
//   - IDLE, lw/sw: stall = 1. At the edge:
//     - Capture ir/o/b.
//     - dmem_req <= 1, dmem_we <= (sw), dmem_addr <= o_in[ADDR_W-1:0], dmem_wdata <= b_in.
//     - valid_out <= 0 (bubble). Go to ACCESS, counter <= 0.
//   - ACCESS: dmem_req/we/addr/wdata stay stable. stall = ~dmem_ready.
//     - dmem_ready = 1: at the edge
//       - dmem_req <= 0.
//       - ir_out/o_out <= captured values; d_out <= lw ? dmem_rdata : 0.
//       - valid_out <= 1. Go to IDLE.
//       - X/M advances on this same edge.
//     - dmem_ready = 0: counter increments.
//     - TIMEOUT != 0 and counter reaches TIMEOUT-1 without ready: at the edge
//       - dmem_req <= 0, err_out <= 1.
//       - Complete as above with d_out = 0, valid_out = 1. Go to IDLE.
//       - stall = 0 in that abort cycle.
// - Memory-op latency: 1 + N cycles, where N = number of ACCESS cycles (N >= 1).
//   Ready in the first ACCESS cycle gives 2 cycles total.
// - valid_out pulses for exactly 1 cycle per completed instruction. It is 0 on every bubble cycle.
// - dmem_ready while in IDLE is ignored.
// - A back-to-back memory op is first seen in IDLE on the cycle after completion.
//   No request overlap.
// - err_out is cleared only by reset.
// TESTING
// - Reset with all inputs nonzero.
//   -> all outputs 0. dmem_req stays 0 while ir_in is non-memory.
// - ALU op ir=0x00A21020, o=5 -> next cycle ir_out=0x00A21020, o_out=5, d_out=0, valid_out=1, stall=0.
// - lw (ir[31:27]=01000), o=0x123, ready after 3 ACCESS cycles, rdata=0xDEADBEEF:
//   - stall is high for 3 cycles and low in the ready cycle.
//   - d_out=0xDEADBEEF and valid_out=1 at cycle 4. dmem_addr=0x123 is held throughout.
// - sw, b=0x55AA, ready in first ACCESS cycle:
//   - dmem_we=1, dmem_wdata=0x55AA.
//   - Completion after 2 cycles with d_out=0. No load data is captured.
// - lw with TIMEOUT=4, ready never asserted:
//   - dmem_req drops after 4 ACCESS cycles.
//   - err_out=1 (sticky), valid_out pulses once with d_out=0.
//   - The next ALU op completes normally.
// - Reset asserted in the 2nd ACCESS cycle:
//   - dmem_req=0 and valid_out=0 next cycle.
//   - A later ready pulse produces no valid_out.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller between the X/M and M/W pipeline latches.
// Decodes lw/sw, runs a req/ready handshake with a multi-cycle data memory,
// stalls the front of the pipeline while an access is outstanding, and can
// abort a stuck access after a configurable number of cycles.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       ir_in,
    input  logic [31:0]       o_in,
    input  logic [31:0]       b_in,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              stall,
    output logic [31:0]       ir_out,
    output logic [31:0]       o_out,
    output logic [31:0]       d_out,
    output logic              valid_out,
    output logic              err_out
);

    localparam logic [4:0] OP_LW = 5'b01000;
    localparam logic [4:0] OP_SW = 5'b00111;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Counter only needs to reach TIMEOUT-1; with TIMEOUT=0 it just wraps unused.
    localparam int unsigned        CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic               TO_EN    = (TIMEOUT != 0);

    logic [0:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      ir_q;
    logic [31:0]      o_q;

    logic in_lw;
    logic in_sw;
    logic in_mem;
    logic cap_lw;
    logic acc_abort;

    // Decode incoming op, detect abort, and derive the combinational stall.
    always_comb begin
        in_lw     = (ir_in[31:27] == OP_LW);
        in_sw     = (ir_in[31:27] == OP_SW);
        in_mem    = in_lw | in_sw;
        cap_lw    = (ir_q[31:27] == OP_LW);
        acc_abort = (state_q == ST_ACCESS) && !dmem_ready && TO_EN && (cnt_q == CNT_LAST);
        if (state_q == ST_IDLE) begin
            stall = in_mem;
        end else begin
            // X/M may advance on the edge that finishes the access, ready or abort.
            stall = !(dmem_ready || acc_abort);
        end
    end

    // Sequencer, memory request registers and M/W-facing outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ir_q       <= '0;
            o_q        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            ir_out     <= '0;
            o_out      <= '0;
            d_out      <= '0;
            valid_out  <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            // valid_out is a one-cycle pulse; every non-completing cycle is a bubble.
            valid_out <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_mem) begin
                        ir_q       <= ir_in;
                        o_q        <= o_in;
                        dmem_req   <= 1'b1;
                        dmem_we    <= in_sw;
                        dmem_addr  <= o_in[ADDR_W-1:0];
                        dmem_wdata <= b_in;
                        cnt_q      <= '0;
                        state_q    <= ST_ACCESS;
                    end else begin
                        ir_out    <= ir_in;
                        o_out     <= o_in;
                        d_out     <= '0;
                        valid_out <= (ir_in != '0);
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ready || acc_abort) begin
                        dmem_req  <= 1'b0;
                        ir_out    <= ir_q;
                        o_out     <= o_q;
                        d_out     <= (dmem_ready && cap_lw) ? dmem_rdata : '0;
                        valid_out <= 1'b1;
                        state_q   <= ST_IDLE;
                        if (acc_abort) begin
                            err_out <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (TIMEOUT=4 instance).
module tb_mem_access_ctrl;

    localparam int unsigned ADDR_W = 12;

    logic              clock;
    logic              reset;
    logic [31:0]       ir_in;
    logic [31:0]       o_in;
    logic [31:0]       b_in;
    logic              dmem_ready;
    logic [31:0]       dmem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic              stall;
    logic [31:0]       ir_out;
    logic [31:0]       o_out;
    logic [31:0]       d_out;
    logic              valid_out;
    logic              err_out;

    int n_tests;
    int n_fail;

    localparam logic [31:0] IR_ALU = 32'h00A2_1020;
    localparam logic [31:0] IR_LW  = 32'h4012_3456;
    localparam logic [31:0] IR_SW  = 32'h3800_0010;

    mem_access_ctrl #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ir_in      (ir_in),
        .o_in       (o_in),
        .b_in       (b_in),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .stall      (stall),
        .ir_out     (ir_out),
        .o_out      (o_out),
        .d_out      (d_out),
        .valid_out  (valid_out),
        .err_out    (err_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle; land just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        ir_in      = 32'hFFFF_FFFF;
        o_in       = 32'hFFFF_FFFF;
        b_in       = 32'hFFFF_FFFF;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        tick();
        tick();
        n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", dmem_req); end
        n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b exp 0", dmem_we); end
        n_tests++; if (dmem_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %h exp 0", dmem_addr); end
        n_tests++; if (dmem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h exp 0", dmem_wdata); end
        n_tests++; if (ir_out !== 32'h0) begin n_fail++; $display("FAIL rst_ir: got %h exp 0", ir_out); end
        n_tests++; if (o_out !== 32'h0) begin n_fail++; $display("FAIL rst_o: got %h exp 0", o_out); end
        n_tests++; if (d_out !== 32'h0) begin n_fail++; $display("FAIL rst_d: got %h exp 0", d_out); end
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", valid_out); end
        n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b exp 0", err_out); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b exp 0", stall); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL post_rst_req[%0d]: got %b exp 0", i, dmem_req); end
        end
        n_tests++; if (valid_out !== 1'b1 || ir_out !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL post_rst_alu: got v=%b ir=%h exp v=1 ir=ffffffff", valid_out, ir_out);
        end
        ir_in      = 32'h0;
        dmem_ready = 1'b0;
        tick();
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL nop_valid: got %b exp 0", valid_out); end
    endtask

    task automatic test_alu();
        ir_in = IR_ALU;
        o_in  = 32'd5;
        b_in  = 32'd7;
        @(negedge clock);
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b exp 0", stall); end
        tick();
        n_tests++; if (ir_out !== IR_ALU) begin n_fail++; $display("FAIL alu_ir: got %h exp %h", ir_out, IR_ALU); end
        n_tests++; if (o_out !== 32'd5) begin n_fail++; $display("FAIL alu_o: got %h exp 5", o_out); end
        n_tests++; if (d_out !== 32'h0) begin n_fail++; $display("FAIL alu_d: got %h exp 0", d_out); end
        n_tests++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL alu_valid: got %b exp 1", valid_out); end
        n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_req: got %b exp 0", dmem_req); end
        ir_in = 32'h0;
        tick();
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got %b exp 0", valid_out); end
    endtask

    task automatic test_lw_wait();
        ir_in      = IR_LW;
        o_in       = 32'h0000_0123;
        b_in       = 32'h0BAD_0BAD;
        dmem_ready = 1'b0;
        @(negedge clock);
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_stall_idle: got %b exp 1", stall); end
        tick();
        n_tests++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL lw_we: got %b exp 0", dmem_we); end
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL lw_bubble: got %b exp 0", valid_out); end
        // Two waiting ACCESS cycles.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_stall_acc[%0d]: got %b exp 1", i, stall); end
            n_tests++; if (dmem_req !== 1'b1 || dmem_addr !== 12'h123) begin
                n_fail++; $display("FAIL lw_req_acc[%0d]: got req=%b addr=%h exp req=1 addr=123", i, dmem_req, dmem_addr);
            end
            tick();
        end
        // Third ACCESS cycle: memory answers; X/M advances to a nop.
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        ir_in      = 32'h0;
        @(negedge clock);
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_stall_ready: got %b exp 0", stall); end
        n_tests++; if (dmem_addr !== 12'h123) begin n_fail++; $display("FAIL lw_addr_ready: got %h exp 123", dmem_addr); end
        tick();
        dmem_ready = 1'b0;
        n_tests++; if (d_out !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_d: got %h exp deadbeef", d_out); end
        n_tests++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL lw_valid: got %b exp 1", valid_out); end
        n_tests++; if (ir_out !== IR_LW || o_out !== 32'h123) begin
            n_fail++; $display("FAIL lw_iro: got ir=%h o=%h exp ir=%h o=123", ir_out, o_out, IR_LW);
        end
        n_tests++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got %b exp 0", dmem_req); end
        // Ready while idle must be ignored.
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        n_tests++; if (valid_out !== 1'b0 || dmem_req !== 1'b0) begin
            n_fail++; $display("FAIL idle_ready: got v=%b req=%b exp 0 0", valid_out, dmem_req);
        end
    endtask

    task automatic test_sw();
        ir_in      = IR_SW;
        o_in       = 32'h0001_2ABC;
        b_in       = 32'h0000_55AA;
        dmem_ready = 1'b0;
        tick();
        n_tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            n_fail++; $display("FAIL sw_req_we: got req=%b we=%b exp 1 1", dmem_req, dmem_we);
        end
        n_tests++; if (dmem_wdata !== 32'h55AA) begin n_fail++; $display("FAIL sw_wdata: got %h exp 55aa", dmem_wdata); end
        n_tests++; if (dmem_addr !== 12'hABC) begin n_fail++; $display("FAIL sw_addr: got %h exp abc", dmem_addr); end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1234_5678;
        ir_in      = 32'h0;
        @(negedge clock);
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw_stall: got %b exp 0", stall); end
        tick();
        dmem_ready = 1'b0;
        n_tests++; if (valid_out !== 1'b1 || d_out !== 32'h0) begin
            n_fail++; $display("FAIL sw_done: got v=%b d=%h exp v=1 d=0", valid_out, d_out);
        end
        n_tests++; if (ir_out !== IR_SW || o_out !== 32'h0001_2ABC) begin
            n_fail++; $display("FAIL sw_iro: got ir=%h o=%h exp ir=%h o=12abc", ir_out, o_out, IR_SW);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        ir_in      = IR_SW;
        o_in       = 32'h0000_0010;
        b_in       = 32'h0000_0077;
        dmem_ready = 1'b0;
        tick();
        dmem_ready = 1'b1;
        ir_in      = IR_LW;
        o_in       = 32'h0000_0020;
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        // First op completed; second op sits in IDLE with no request yet.
        n_tests++; if (valid_out !== 1'b1 || ir_out !== IR_SW) begin
            n_fail++; $display("FAIL b2b_first: got v=%b ir=%h exp v=1 ir=%h", valid_out, ir_out, IR_SW);
        end
        n_tests++; if (dmem_req !== 1'b0 || stall !== 1'b1) begin
            n_fail++; $display("FAIL b2b_gap: got req=%b stall=%b exp 0 1", dmem_req, stall);
        end
        dmem_ready = 1'b0;
        tick();
        n_tests++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 12'h020) begin
            n_fail++; $display("FAIL b2b_req2: got req=%b we=%b addr=%h exp 1 0 020", dmem_req, dmem_we, dmem_addr);
        end
        dmem_ready = 1'b1;
        ir_in      = 32'h0;
        tick();
        dmem_ready = 1'b0;
        n_tests++; if (valid_out !== 1'b1 || d_out !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL b2b_second: got v=%b d=%h exp v=1 d=cafef00d", valid_out, d_out);
        end
        tick();
    endtask

    task automatic test_timeout();
        ir_in      = 32'h4000_0001;
        o_in       = 32'h0000_0040;
        dmem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_tests++; if (stall !== 1'b1 || dmem_req !== 1'b1) begin
                n_fail++; $display("FAIL to_wait[%0d]: got stall=%b req=%b exp 1 1", i, stall, dmem_req);
            end
            tick();
        end
        // Fourth ACCESS cycle aborts; X/M advances to an ALU op.
        ir_in = IR_ALU;
        o_in  = 32'd9;
        @(negedge clock);
        n_tests++; if (stall !== 1'b0 || dmem_req !== 1'b1) begin
            n_fail++; $display("FAIL to_abort_cyc: got stall=%b req=%b exp 0 1", stall, dmem_req);
        end
        tick();
        n_tests++; if (dmem_req !== 1'b0 || err_out !== 1'b1) begin
            n_fail++; $display("FAIL to_abort: got req=%b err=%b exp 0 1", dmem_req, err_out);
        end
        n_tests++; if (valid_out !== 1'b1 || d_out !== 32'h0 || ir_out !== 32'h4000_0001) begin
            n_fail++; $display("FAIL to_complete: got v=%b d=%h ir=%h exp 1 0 40000001", valid_out, d_out, ir_out);
        end
        tick();
        ir_in = 32'h0;
        n_tests++; if (valid_out !== 1'b1 || ir_out !== IR_ALU || o_out !== 32'd9) begin
            n_fail++; $display("FAIL to_next_alu: got v=%b ir=%h o=%h exp 1 %h 9", valid_out, ir_out, o_out, IR_ALU);
        end
        tick();
        n_tests++; if (err_out !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++; $display("FAIL to_sticky: got err=%b v=%b exp 1 0", err_out, valid_out);
        end
    endtask

    task automatic test_reset_mid_access();
        ir_in      = IR_LW;
        o_in       = 32'h0000_0055;
        dmem_ready = 1'b0;
        tick();
        tick();
        // Second ACCESS cycle: reset.
        reset = 1'b1;
        ir_in = 32'h0;
        tick();
        reset = 1'b0;
        n_tests++; if (dmem_req !== 1'b0 || valid_out !== 1'b0) begin
            n_fail++; $display("FAIL rmid_after: got req=%b v=%b exp 0 0", dmem_req, valid_out);
        end
        n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL rmid_err_clr: got %b exp 0", err_out); end
        tick();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111_2222;
        tick();
        dmem_ready = 1'b0;
        n_tests++; if (valid_out !== 1'b0 || d_out !== 32'h0) begin
            n_fail++; $display("FAIL rmid_late_ready: got v=%b d=%h exp 0 0", valid_out, d_out);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_alu();
        test_lw_wait();
        test_sw();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
